mmio_bridge: RTL and testbench

- Memory-mapped I/O bridge between the processor M stage and the data memory, PS/2 keyboard and LCD.
- Consumes the M-stage address, store data and write/read strobes.
- Steers each access either to dmem or to on-block I/O registers.
- Returns registered read data to the M/W pipeline register.
- Buffers incoming PS/2 keycodes in a small FIFO so `lw` polling cannot miss keys.

---
 rtl/mmio_bridge_pkg.sv | 39 +++
 rtl/mmio_bridge_ps2_key_fifo.sv | 64 ++++++
 rtl/mmio_bridge.sv | 139 +++++++++++++
 tb/tb_mmio_bridge.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bridge_pkg.sv
// Shared constants for the M-stage MMIO bridge: I/O base address,
// register offsets within the I/O window, STATUS bit layout and the
// read-path region select type.
package mmio_bridge_pkg;

    localparam logic [11:0] IO_BASE_DEFAULT = 12'hFF0;

    // Offsets from IO_BASE
    localparam logic [11:0] STATUS_OFF = 12'd0;
    localparam logic [11:0] KEY_OFF    = 12'd1;
    localparam logic [11:0] LCD_OFF    = 12'd2;

    // STATUS register bit positions
    localparam int unsigned ST_NOT_EMPTY = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVERFLOW  = 2;
    localparam int unsigned ST_COUNT_LSB = 4;
    localparam int unsigned ST_COUNT_W   = 4;

    typedef enum logic {
        SEL_DMEM = 1'b0,
        SEL_IO   = 1'b1
    } rd_sel_e;

    // Assemble the STATUS read word; unlisted bits are zero.
    function automatic logic [31:0] status_word(input logic              not_empty,
                                                input logic              full,
                                                input logic              overflow,
                                                input logic [ST_COUNT_W-1:0] count);
        logic [31:0] w;
        w = 32'd0;
        w[ST_NOT_EMPTY] = not_empty;
        w[ST_FULL]      = full;
        w[ST_OVERFLOW]  = overflow;
        w[ST_COUNT_LSB +: ST_COUNT_W] = count;
        return w;
    endfunction

endpackage

// File: rtl/mmio_bridge_ps2_key_fifo.sv
// PS/2 keycode FIFO.
// Ports: clock/reset (sync, active-high); push/push_data enqueue a keycode;
// pop dequeues the head; head/count/full/empty report state;
// overflow_event flags a push dropped because the FIFO was full.
module ps2_key_fifo #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               push,
    input  logic [7:0]                         push_data,
    input  logic                               pop,
    output logic [7:0]                         head,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               full,
    output logic                               empty,
    output logic                               overflow_event
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;
    logic             do_push;

    // A pop on a full FIFO frees the slot the same-cycle push needs.
    always_comb begin
        do_pop         = pop && (count_q != '0);
        do_push        = push && ((count_q != CNT_W'(FIFO_DEPTH)) || do_pop);
        overflow_event = push && (count_q == CNT_W'(FIFO_DEPTH)) && !do_pop;
        rd_ptr_d       = rd_ptr_q + PTR_W'(do_pop);
        wr_ptr_d       = wr_ptr_q + PTR_W'(do_push);
        count_d        = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed while count is non-zero.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/mmio_bridge.sv
// MMIO bridge between the M stage and dmem / PS/2 keyboard / LCD.
// Ports: clock/reset (sync, active-high); mem_* from the M stage, mem_rdata
// back to M/W (one-cycle latency); dmem_* to the data memory; ps2_* from the
// PS/2 controller; lcd_write/lcd_data to the LCD.
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [11:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic [11:0] dmem_address,
    output logic [31:0] dmem_data,
    output logic        dmem_wren,
    input  logic [31:0] dmem_q,
    input  logic        ps2_key_pressed,
    input  logic [7:0]  ps2_out,
    output logic        lcd_write,
    output logic [31:0] lcd_data
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             is_io;
    logic [11:0]      io_off;
    logic             status_rd;
    logic             key_rd;
    logic             lcd_wr;
    logic             key_push;
    logic [31:0]      io_rval;
    logic [31:0]      rdata_now;

    logic [7:0]       fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_ovf_event;

    logic             key_prev_q,  key_prev_d;
    logic             ovf_q,       ovf_d;
    logic             rd_pend_q,   rd_pend_d;
    rd_sel_e          rd_sel_q,    rd_sel_d;
    logic [31:0]      io_val_q,    io_val_d;
    logic [31:0]      rdata_q,     rdata_d;
    logic             lcd_write_q, lcd_write_d;
    logic [31:0]      lcd_data_q,  lcd_data_d;

    ps2_key_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock         (clock),
        .reset         (reset),
        .push          (key_push),
        .push_data     (ps2_out),
        .pop           (key_rd),
        .head          (fifo_head),
        .count         (fifo_count),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .overflow_event(fifo_ovf_event)
    );

    // Address decode and I/O read value
    always_comb begin
        is_io     = (mem_addr >= IO_BASE);
        io_off    = mem_addr - IO_BASE;
        status_rd = mem_re && is_io && (io_off == STATUS_OFF);
        key_rd    = mem_re && is_io && (io_off == KEY_OFF);
        lcd_wr    = mem_we && is_io && (io_off == LCD_OFF);
        key_push  = ps2_key_pressed && !key_prev_q;

        io_rval = 32'd0;
        if (status_rd) begin
            io_rval = status_word(!fifo_empty, fifo_full, ovf_q, ST_COUNT_W'(fifo_count));
        end else if (key_rd && !fifo_empty) begin
            io_rval = 32'(fifo_head);
        end
    end

    // Load data appears the cycle after mem_re; otherwise the last value is held.
    assign rdata_now = rd_pend_q ? ((rd_sel_q == SEL_IO) ? io_val_q : dmem_q) : rdata_q;

    // Next-state for the read pipeline, sticky overflow, edge detect and LCD
    always_comb begin
        key_prev_d  = ps2_key_pressed;
        rd_pend_d   = mem_re;
        rd_sel_d    = rd_sel_q;
        io_val_d    = io_val_q;
        rdata_d     = rdata_now;
        lcd_write_d = lcd_wr;
        lcd_data_d  = lcd_data_q;

        if (mem_re) begin
            rd_sel_d = is_io ? SEL_IO : SEL_DMEM;
            io_val_d = io_rval;
        end
        // A STATUS read clears the sticky, but a same-cycle overflow wins.
        ovf_d = (ovf_q && !status_rd) || fifo_ovf_event;
        if (lcd_wr) begin
            lcd_data_d = mem_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_prev_q  <= 1'b0;
            ovf_q       <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_sel_q    <= SEL_DMEM;
            io_val_q    <= 32'd0;
            rdata_q     <= 32'd0;
            lcd_write_q <= 1'b0;
            lcd_data_q  <= 32'd0;
        end else begin
            key_prev_q  <= key_prev_d;
            ovf_q       <= ovf_d;
            rd_pend_q   <= rd_pend_d;
            rd_sel_q    <= rd_sel_d;
            io_val_q    <= io_val_d;
            rdata_q     <= rdata_d;
            lcd_write_q <= lcd_write_d;
            lcd_data_q  <= lcd_data_d;
        end
    end

    assign mem_rdata    = rdata_now;
    assign dmem_address = mem_addr;
    assign dmem_data    = mem_wdata;
    assign dmem_wren    = mem_we && !is_io;
    assign lcd_write    = lcd_write_q;
    assign lcd_data     = lcd_data_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: queue-based model of the keyboard FIFO, sticky flag,
// LCD port and load return path, compared every cycle, plus directed reads
// with literal expected values.
module tb_mmio_bridge;

    logic        clock;
    logic        reset;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic [11:0] dmem_address;
    logic [31:0] dmem_data;
    logic        dmem_wren;
    logic [31:0] dmem_q;
    logic        ps2_key_pressed;
    logic [7:0]  ps2_out;
    logic        lcd_write;
    logic [31:0] lcd_data;

    int checks   = 0;
    int failures = 0;

    mmio_bridge dut (
        .clock          (clock),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .mem_rdata      (mem_rdata),
        .dmem_address   (dmem_address),
        .dmem_data      (dmem_data),
        .dmem_wren      (dmem_wren),
        .dmem_q         (dmem_q),
        .ps2_key_pressed(ps2_key_pressed),
        .ps2_out        (ps2_out),
        .lcd_write      (lcd_write),
        .lcd_data       (lcd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int DEPTH = 8;
    logic [7:0]  m_q[$];
    bit          m_valid   = 0;
    bit          m_prev    = 0;
    bit          m_ovf     = 0;
    bit          m_pend    = 0;
    bit          m_pend_io = 0;
    logic [31:0] m_pend_val = 0;
    logic [31:0] m_hold    = 0;
    bit          m_lcd_wr  = 0;
    logic [31:0] m_lcd_d   = 0;

    always @(posedge clock) begin
        bit          io, push, popped, full_before, st_rd, key_rd, ovf_ev;
        int          off;
        logic [31:0] v;
        m_valid = 1;
        if (reset) begin
            m_q.delete();
            m_prev = 0; m_ovf = 0; m_pend = 0; m_hold = 0;
            m_lcd_wr = 0; m_lcd_d = 0;
        end else begin
            io     = (mem_addr >= 12'hFF0);
            off    = int'(mem_addr) - 'hFF0;
            st_rd  = mem_re && io && off == 0;
            key_rd = mem_re && io && off == 1;
            push   = ps2_key_pressed && !m_prev;
            m_prev = ps2_key_pressed;
            v = 0;
            if (st_rd)
                v = (m_q.size() << 4) | (m_ovf << 2) |
                    ((m_q.size() == DEPTH) << 1) | (m_q.size() != 0);
            else if (key_rd && m_q.size() != 0)
                v = 32'(m_q[0]);
            full_before = (m_q.size() == DEPTH);
            popped = key_rd && m_q.size() != 0;
            if (popped) void'(m_q.pop_front());
            ovf_ev = 0;
            if (push) begin
                if (full_before && !popped) ovf_ev = 1;
                else m_q.push_back(ps2_out);
            end
            m_ovf = (m_ovf && !st_rd) || ovf_ev;
            m_lcd_wr = mem_we && io && off == 2;
            if (m_lcd_wr) m_lcd_d = mem_wdata;
            m_pend     = mem_re;
            m_pend_io  = io;
            m_pend_val = v;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (m_valid) begin
            if (m_pend) m_hold = m_pend_io ? m_pend_val : dmem_q;
            check("mem_rdata", mem_rdata, m_hold);
            check("lcd_write", 32'(lcd_write), 32'(m_lcd_wr));
            check("lcd_data", lcd_data, m_lcd_d);
            check("dmem_address", 32'(dmem_address), 32'(mem_addr));
            check("dmem_data", dmem_data, mem_wdata);
            check("dmem_wren", 32'(dmem_wren), 32'(mem_we && mem_addr < 12'hFF0));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_read(input logic [11:0] a, input logic [31:0] dq,
                           input logic [31:0] exp, input string nm);
        mem_addr = a;
        mem_re   = 1'b1;
        tick();
        mem_re = 1'b0;
        dmem_q = dq;
        @(negedge clock);
        check(nm, mem_rdata, exp);
        tick();
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                            input logic exp_wren, input string nm);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        @(negedge clock);
        check(nm, 32'(dmem_wren), 32'(exp_wren));
        tick();
        mem_we = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        ps2_out = k;
        ps2_key_pressed = 1'b1;
        repeat (5) tick();
        ps2_key_pressed = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        logic [7:0] k;
        reset = 1'b1; mem_addr = '0; mem_wdata = '0; mem_we = 0; mem_re = 0;
        dmem_q = 32'h0BAD_F00D; ps2_key_pressed = 0; ps2_out = '0;
        repeat (2) tick();
        @(negedge clock);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_lcd_write", 32'(lcd_write), 32'd0);
        check("rst_lcd_data", lcd_data, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // dmem load and hold
        do_read(12'h010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "lw_dmem");
        dmem_q = 32'h1234_5678;
        @(negedge clock);
        check("rdata_hold", mem_rdata, 32'hDEAD_BEEF);
        tick();

        // stores
        do_write(12'h005, 32'h55, 1'b1, "sw_dmem_wren");
        do_write(12'hFF2, 32'h41, 1'b0, "sw_lcd_wren");
        @(negedge clock);
        check("lcd_strobe", 32'(lcd_write), 32'd1);
        check("lcd_value", lcd_data, 32'h41);
        tick();
        @(negedge clock);
        check("lcd_strobe_end", 32'(lcd_write), 32'd0);
        check("lcd_value_held", lcd_data, 32'h41);
        tick();
        do_write(12'hFF2, 32'h42, 1'b0, "lcd_b2b_a");
        do_write(12'hFF2, 32'h43, 1'b0, "lcd_b2b_b");
        do_write(12'hFF3, 32'h99, 1'b0, "sw_unused_io");
        tick();
        do_read(12'hFF8, 32'h0, 32'h0, "lw_unused_io");

        // three keys
        press(8'h1C); press(8'h32); press(8'h21);
        do_read(12'hFF0, 32'h0, 32'h31, "status_3keys");
        do_read(12'hFF1, 32'h0, 32'h1C, "key0");
        do_read(12'hFF1, 32'h0, 32'h32, "key1");
        do_read(12'hFF1, 32'h0, 32'h21, "key2");
        do_read(12'hFF1, 32'h0, 32'h00, "key_empty");
        do_read(12'hFF0, 32'h0, 32'h00, "status_empty");

        // overflow
        for (int i = 0; i < 9; i++) press(8'(8'h10 + i));
        do_read(12'hFF0, 32'h0, 32'h87, "status_ovf");
        do_read(12'hFF0, 32'h0, 32'h83, "status_ovf_clr");
        for (int i = 0; i < 8; i++) begin
            k = 8'(8'h10 + i);
            do_read(12'hFF1, 32'h0, 32'(k), "key_ovf_order");
        end
        do_read(12'hFF0, 32'h0, 32'h00, "status_drained");

        // full FIFO: pop and push together
        for (int i = 0; i < 8; i++) press(8'(8'h50 + i));
        ps2_out = 8'h99;
        ps2_key_pressed = 1'b1;
        do_read(12'hFF1, 32'h0, 32'h50, "full_pop_push");
        repeat (3) tick();
        ps2_key_pressed = 1'b0;
        tick();
        do_read(12'hFF0, 32'h0, 32'h83, "status_full_pp");
        for (int i = 1; i < 8; i++) begin
            k = 8'(8'h50 + i);
            do_read(12'hFF1, 32'h0, 32'(k), "key_full_pp");
        end
        do_read(12'hFF1, 32'h0, 32'h99, "key_last_pushed");

        // empty FIFO: pop and push together
        ps2_out = 8'hAB;
        ps2_key_pressed = 1'b1;
        do_read(12'hFF1, 32'h0, 32'h00, "empty_pop_push");
        ps2_key_pressed = 1'b0;
        tick();
        do_read(12'hFF0, 32'h0, 32'h11, "status_empty_pp");
        do_read(12'hFF1, 32'h0, 32'hAB, "key_empty_pp");

        // reset mid-operation
        for (int i = 0; i < 5; i++) press(8'(8'h60 + i));
        mem_addr = 12'hFF2; mem_wdata = 32'h77; mem_we = 1'b1;
        reset = 1'b1;
        tick();
        mem_we = 1'b0;
        @(negedge clock);
        check("rst_mid_lcd_write", 32'(lcd_write), 32'd0);
        check("rst_mid_lcd_data", lcd_data, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        do_read(12'hFF0, 32'h0, 32'h00, "status_after_rst");

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
